io_key_sw_device: RTL and testbench
===================================

IO_KEY_SW_DEVICE -- requirements
Module: io_key_sw_device

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning the number of consecutive stable synchronized samples required before an input change is accepted (legal range 2..2^20).
REQ-002 The module SHALL have parameter DBITS, default 32, meaning the bus address and data width.
REQ-003 Port clk, in, 1: the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 Port reset, in, 1: asynchronous, active-low reset.
REQ-005 Port addr, in, DBITS: byte address from the processor.
REQ-006 Port wr_en, in, 1: store strobe, qualified by addr.
REQ-007 Port wdata, in, DBITS: store data.
REQ-008 Port rd_en, in, 1: load strobe, qualified by addr.
REQ-009 Port rdata, out, DBITS: load data, combinational from addr and register state.
REQ-010 Port key_raw, in, 4: board KEY pins, active-low, asynchronous.
REQ-011 Port sw_raw, in, 10: board SW pins, asynchronous.
REQ-012 Port irq, out, 1: level interrupt request.

Function
REQ-013 Register map (full 32-bit compare): KDATA 0xF0000010 (RO), SDATA 0xF0000014 (RO), KCTRL 0xF0000110 (RW), SCTRL 0xF0000114 (RW).
REQ-014 KDATA[3:0] SHALL equal the inverted, debounced key value (pressed=1); SDATA[9:0] SHALL equal the debounced switch value; all upper bits read 0.
REQ-015 xCTRL bit0 = Ready, bit2 = Overrun, bit8 = IE; all other bits read 0.
REQ-016 Each raw input SHALL pass a 2-flop synchronizer, then a stability counter; the debounced value SHALL update on the edge where the synchronized value has been constant for DEBOUNCE_CYCLES consecutive samples, i.e. 2+DEBOUNCE_CYCLES edges after a clean raw change.
REQ-017 Any synchronized change before the count completes SHALL restart the counter without updating the debounced value.
REQ-018 A change of the debounced value SHALL set Ready on the same edge it commits.
REQ-019 A debounced change while Ready is already 1 and no clearing read occurs that cycle SHALL set Overrun; Ready stays 1.
REQ-020 rd_en with addr=KDATA (SDATA) SHALL clear KCTRL (SCTRL) Ready on the next edge.
REQ-021 A debounced change coincident with a clearing read SHALL leave Ready=1 and SHALL NOT set Overrun.
REQ-022 A write to xCTRL SHALL load IE from wdata[8]; writing wdata[2]=0 SHALL clear Overrun, writing 1 SHALL leave it unchanged; wdata[0] SHALL be ignored.
REQ-023 Writes to KDATA, SDATA, or unmapped addresses SHALL have no effect; reads of unmapped addresses SHALL return 0 and have no side effect.
REQ-024 irq SHALL be registered: irq <= (KReady & KIE) | (SReady & SIE), one edge after the condition.
REQ-025 Simultaneous key and switch events SHALL be handled independently in the same cycle.

Reset
REQ-026 On reset low: key synchronizers and debounced key value SHALL reset to 4'b1111 (released), switch synchronizers and debounced value to 0, counters to 0, Ready/Overrun/IE to 0, irq to 0.
REQ-027 Reset asserted mid-debounce SHALL discard the pending value; switches held non-zero across reset release SHALL produce an SDATA update and Ready=1 after 2+DEBOUNCE_CYCLES edges.

Structure
REQ-028 Register addresses and xCTRL bit positions SHALL live in shared package io_dev_pkg, alongside the existing HEX/LEDR/LEDG addresses.
REQ-029 Synchronizer plus stability counter SHALL be sub-module io_debouncer (parameters WIDTH, DEBOUNCE_CYCLES, RESET_VALUE; outputs value and a one-cycle changed pulse), instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 key_raw 1111->1110 held -> KDATA=0x1 and KCTRL=0x1 exactly 6 edges later; read KDATA -> KCTRL=0x0 next cycle.
REQ-031 sw_raw toggles 0x000->0x3FF->0x000 every 2 cycles, then settles at 0x155 -> SDATA stays 0 through the glitching, becomes 0x155 6 edges after settling.
REQ-032 Two key changes without a read -> KCTRL=0x5; write KCTRL 0x000 -> KCTRL=0x1; read KDATA -> 0x0.
REQ-033 Write SCTRL 0x100, then switch change -> irq=1 one edge after SReady sets; read SDATA -> irq=0 two edges later.
REQ-034 Debounced commit in the same cycle as a KDATA read -> KCTRL=0x1, Overrun=0.
REQ-035 Reset pulsed low mid-debounce with sw_raw=0x2A0 -> all registers 0 immediately; SDATA=0x2A0, SCTRL=0x1 6 edges after release; read 0xF0000018 -> 0.

Source files
------------

// File: rtl/io_dev_pkg.sv
// Shared I/O device package: memory-mapped addresses for the board
// peripherals, plus the bit positions in the key/switch control registers.
package io_dev_pkg;

    // Display and LED outputs already on this bus
    localparam logic [31:0] HEX_ADDR   = 32'hF000_0000;
    localparam logic [31:0] LEDR_ADDR  = 32'hF000_0004;
    localparam logic [31:0] LEDG_ADDR  = 32'hF000_0008;

    // Key / switch input device
    localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
    localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
    localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
    localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

    // Bit positions inside KCTRL / SCTRL
    localparam int CTRL_READY_BIT   = 0;
    localparam int CTRL_OVERRUN_BIT = 2;
    localparam int CTRL_IE_BIT      = 8;

    localparam int KEY_WIDTH = 4;
    localparam int SW_WIDTH  = 10;

    // Assemble a control-register read word; bits not listed read 0
    function automatic logic [31:0] ctrl_word(input logic ready,
                                              input logic overrun,
                                              input logic ie);
        logic [31:0] w;
        w                   = '0;
        w[CTRL_READY_BIT]   = ready;
        w[CTRL_OVERRUN_BIT] = overrun;
        w[CTRL_IE_BIT]      = ie;
        return w;
    endfunction

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchronizer followed by a stability counter. The debounced
// value only moves once the synchronized input has held the same new value
// for DEBOUNCE_CYCLES consecutive samples; any change restarts the count.
// 'changed' is high during the cycle whose closing edge commits a new value,
// so a consumer registering on 'changed' acts on the same edge as the commit.
module io_debouncer #(
    parameter int               WIDTH           = 1,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic             changed
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] cand_reg;   // last synchronized sample seen
    logic [WIDTH-1:0] value_reg;
    logic [CW-1:0]    cnt_reg;    // samples of cand_reg seen in a row

    // Commit fires when this edge delivers the final stable sample
    assign changed = (sync2_reg == cand_reg) && (cand_reg != value_reg) &&
                     (cnt_reg == LAST);
    assign value   = value_reg;

    // Synchronize, track the candidate value and count its stability
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= RESET_VALUE;
            sync2_reg <= RESET_VALUE;
            cand_reg  <= RESET_VALUE;
            value_reg <= RESET_VALUE;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != cand_reg) begin
                // New synchronized value: this sample is the first of the run
                cand_reg <= sync2_reg;
                cnt_reg  <= CW'(1);
            end else if (cand_reg == value_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == LAST) begin
                value_reg <= cand_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_key_sw_device.sv
// Memory-mapped key/switch input device. Keys and switches are debounced
// independently; each channel has a Ready/Overrun/IE control register and
// the two channels share one registered level interrupt.
module io_key_sw_device
    import io_dev_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DBITS           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wdata,
    input  logic             rd_en,
    output logic [DBITS-1:0] rdata,
    input  logic [3:0]       key_raw,
    input  logic [9:0]       sw_raw,
    output logic             irq
);

    localparam int CH_KEY = 0;
    localparam int CH_SW  = 1;

    logic [KEY_WIDTH-1:0] key_db;
    logic [SW_WIDTH-1:0]  sw_db;

    // Per-channel decoded strobes and control state (index 0 key, 1 switch)
    logic [1:0] ch_changed;
    logic [1:0] ch_clr;
    logic [1:0] ch_wr;
    logic [1:0] ready_reg;
    logic [1:0] overrun_reg;
    logic [1:0] ie_reg;
    logic       irq_reg;

    // Only IE and the Overrun-clear bit of a control write are meaningful
    logic unused_wdata;
    assign unused_wdata = ^{wdata[DBITS-1:9], wdata[7:3], wdata[1:0]};

    io_debouncer #(
        .WIDTH           (KEY_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     ({KEY_WIDTH{1'b1}})
    ) u_key_db (
        .clk     (clk),
        .reset   (reset),
        .raw     (key_raw),
        .value   (key_db),
        .changed (ch_changed[CH_KEY])
    );

    io_debouncer #(
        .WIDTH           (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     ({SW_WIDTH{1'b0}})
    ) u_sw_db (
        .clk     (clk),
        .reset   (reset),
        .raw     (sw_raw),
        .value   (sw_db),
        .changed (ch_changed[CH_SW])
    );

    // A load from a data register acknowledges that channel's Ready
    assign ch_clr[CH_KEY] = rd_en && (addr == DBITS'(KDATA_ADDR));
    assign ch_clr[CH_SW]  = rd_en && (addr == DBITS'(SDATA_ADDR));
    assign ch_wr[CH_KEY]  = wr_en && (addr == DBITS'(KCTRL_ADDR));
    assign ch_wr[CH_SW]   = wr_en && (addr == DBITS'(SCTRL_ADDR));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ctrl
            // Ready / Overrun / IE update for one channel
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ready_reg[gi]   <= 1'b0;
                    overrun_reg[gi] <= 1'b0;
                    ie_reg[gi]      <= 1'b0;
                end else begin
                    // A new value always leaves Ready set, even if read now
                    if (ch_changed[gi]) begin
                        ready_reg[gi] <= 1'b1;
                    end else if (ch_clr[gi]) begin
                        ready_reg[gi] <= 1'b0;
                    end

                    if (ch_wr[gi]) begin
                        ie_reg[gi] <= wdata[CTRL_IE_BIT];
                    end

                    // Losing an unread value outranks a software clear
                    if (ch_changed[gi] && ready_reg[gi] && !ch_clr[gi]) begin
                        overrun_reg[gi] <= 1'b1;
                    end else if (ch_wr[gi] && !wdata[CTRL_OVERRUN_BIT]) begin
                        overrun_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Level interrupt, registered one edge behind the Ready/IE state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(ready_reg & ie_reg);
        end
    end

    assign irq = irq_reg;

    // Combinational read mux; keys are shown pressed-high
    always_comb begin
        rdata = '0;
        if (addr == DBITS'(KDATA_ADDR)) begin
            rdata[KEY_WIDTH-1:0] = ~key_db;
        end else if (addr == DBITS'(SDATA_ADDR)) begin
            rdata[SW_WIDTH-1:0] = sw_db;
        end else if (addr == DBITS'(KCTRL_ADDR)) begin
            rdata = DBITS'(ctrl_word(ready_reg[CH_KEY], overrun_reg[CH_KEY],
                                     ie_reg[CH_KEY]));
        end else if (addr == DBITS'(SCTRL_ADDR)) begin
            rdata = DBITS'(ctrl_word(ready_reg[CH_SW], overrun_reg[CH_SW],
                                     ie_reg[CH_SW]));
        end
    end

endmodule

// File: tb/tb_io_key_sw_device.sv
// Directed bench for io_key_sw_device with DEBOUNCE_CYCLES=4: a table of
// register write/readback vectors followed by multi-cycle debounce sequences.
module tb_io_key_sw_device;
    import io_dev_pkg::*;

    localparam logic [31:0] UNMAPPED = 32'hF000_0018;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] wdata;
    logic        rd_en;
    logic [31:0] rdata;
    logic [3:0]  key_raw;
    logic [9:0]  sw_raw;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          do_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    io_key_sw_device #(
        .DEBOUNCE_CYCLES (4),
        .DBITS           (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .rd_en   (rd_en),
        .rdata   (rdata),
        .key_raw (key_raw),
        .sw_raw  (sw_raw),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic check_reg(input string name, input logic [31:0] a,
                             input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
        addr = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic read_clear(input logic [31:0] a);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        addr  = 32'h0;
    endtask

    initial begin
        // Register-map vectors: optional write, then readback
        vecs[0]  = '{1'b0, 32'h0,      32'h0,         KDATA_ADDR, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,      32'h0,         SDATA_ADDR, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,      32'h0,         KCTRL_ADDR, 32'h0};
        vecs[3]  = '{1'b0, 32'h0,      32'h0,         SCTRL_ADDR, 32'h0};
        vecs[4]  = '{1'b1, KCTRL_ADDR, 32'h0000_01FF, KCTRL_ADDR, 32'h100};
        vecs[5]  = '{1'b1, SCTRL_ADDR, 32'hFFFF_FFFF, SCTRL_ADDR, 32'h100};
        vecs[6]  = '{1'b1, KDATA_ADDR, 32'h0000_000F, KDATA_ADDR, 32'h0};
        vecs[7]  = '{1'b1, UNMAPPED,   32'h0000_0FFF, KCTRL_ADDR, 32'h100};
        vecs[8]  = '{1'b0, 32'h0,      32'h0,         UNMAPPED,   32'h0};
        vecs[9]  = '{1'b1, KCTRL_ADDR, 32'h0,         KCTRL_ADDR, 32'h0};
        vecs[10] = '{1'b1, SCTRL_ADDR, 32'h0,         SCTRL_ADDR, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0110, 32'h100,    KCTRL_ADDR, 32'h0};

        reset   = 1'b0;
        addr    = 32'h0;
        wr_en   = 1'b0;
        wdata   = 32'h0;
        rd_en   = 1'b0;
        key_raw = 4'hF;
        sw_raw  = 10'h0;
        repeat (3) tick();
        check("rst_irq", {31'h0, irq}, 32'h0);
        check_reg("rst_kdata", KDATA_ADDR, 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            check_reg($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        // Key press commits exactly 6 edges after the raw change
        key_raw = 4'hE;
        repeat (5) tick();
        check_reg("key_early", KDATA_ADDR, 32'h0);
        tick();
        check_reg("key_kdata", KDATA_ADDR, 32'h1);
        check_reg("key_kctrl", KCTRL_ADDR, 32'h1);
        read_clear(KDATA_ADDR);
        check_reg("key_kctrl_clr", KCTRL_ADDR, 32'h0);

        // Two changes without a read raise Overrun
        key_raw = 4'hC;
        repeat (6) tick();
        check_reg("ovr_kctrl1", KCTRL_ADDR, 32'h1);
        key_raw = 4'h8;
        repeat (6) tick();
        check_reg("ovr_kctrl5", KCTRL_ADDR, 32'h5);
        check_reg("ovr_kdata", KDATA_ADDR, 32'h7);
        bus_write(KCTRL_ADDR, 32'h0);
        check_reg("ovr_wclr", KCTRL_ADDR, 32'h1);
        read_clear(KDATA_ADDR);
        check_reg("ovr_rclr", KCTRL_ADDR, 32'h0);

        // Commit coincident with a clearing read: Ready stays, no Overrun
        key_raw = 4'hE;
        repeat (6) tick();
        check_reg("coin_pre", KCTRL_ADDR, 32'h1);
        key_raw = 4'hF;
        repeat (5) tick();
        addr  = KDATA_ADDR;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        addr  = 32'h0;
        check_reg("coin_kctrl", KCTRL_ADDR, 32'h1);
        check_reg("coin_kdata", KDATA_ADDR, 32'h0);
        read_clear(KDATA_ADDR);

        // Switch glitching must not commit; settled value commits
        for (int i = 0; i < 2; i++) begin
            sw_raw = 10'h3FF;
            repeat (2) tick();
            sw_raw = 10'h000;
            repeat (2) tick();
        end
        check_reg("glitch_sdata", SDATA_ADDR, 32'h0);
        check_reg("glitch_sctrl", SCTRL_ADDR, 32'h0);
        sw_raw = 10'h155;
        repeat (5) tick();
        check_reg("settle_early", SDATA_ADDR, 32'h0);
        tick();
        check_reg("settle_sdata", SDATA_ADDR, 32'h155);
        check_reg("settle_sctrl", SCTRL_ADDR, 32'h1);
        read_clear(SDATA_ADDR);
        check_reg("settle_clr", SCTRL_ADDR, 32'h0);

        // Interrupt timing on the switch channel
        bus_write(SCTRL_ADDR, 32'h100);
        check_reg("irq_ie", SCTRL_ADDR, 32'h100);
        sw_raw = 10'h0AA;
        repeat (6) tick();
        check_reg("irq_sctrl", SCTRL_ADDR, 32'h101);
        check("irq_same_edge", {31'h0, irq}, 32'h0);
        tick();
        check("irq_set", {31'h0, irq}, 32'h1);
        read_clear(SDATA_ADDR);
        check("irq_hold", {31'h0, irq}, 32'h1);
        tick();
        check("irq_drop", {31'h0, irq}, 32'h0);
        bus_write(SCTRL_ADDR, 32'h0);

        // Simultaneous key and switch events are independent
        key_raw = 4'h7;
        sw_raw  = 10'h3FF;
        repeat (6) tick();
        check_reg("sim_kdata", KDATA_ADDR, 32'h8);
        check_reg("sim_sdata", SDATA_ADDR, 32'h3FF);
        check_reg("sim_kctrl", KCTRL_ADDR, 32'h1);
        check_reg("sim_sctrl", SCTRL_ADDR, 32'h1);
        read_clear(KDATA_ADDR);
        check_reg("sim_kclr", KCTRL_ADDR, 32'h0);
        check_reg("sim_sheld", SCTRL_ADDR, 32'h1);
        read_clear(SDATA_ADDR);

        // Reset mid-debounce discards the pending switch value
        bus_write(KCTRL_ADDR, 32'h100);
        key_raw = 4'hF;
        sw_raw  = 10'h2A0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check_reg("mrst_kdata", KDATA_ADDR, 32'h0);
        check_reg("mrst_sdata", SDATA_ADDR, 32'h0);
        check_reg("mrst_kctrl", KCTRL_ADDR, 32'h0);
        check_reg("mrst_sctrl", SCTRL_ADDR, 32'h0);
        check("mrst_irq", {31'h0, irq}, 32'h0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check_reg("post_early", SDATA_ADDR, 32'h0);
        tick();
        check_reg("post_sdata", SDATA_ADDR, 32'h2A0);
        check_reg("post_sctrl", SCTRL_ADDR, 32'h1);
        check_reg("post_kctrl", KCTRL_ADDR, 32'h0);
        check_reg("post_unmap", UNMAPPED, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
